// File: rtl/param_seq_detector.sv
// Serial pattern detector with a runtime-loadable pattern and length,
// optional overlapping matches, and a saturating match counter.
module param_seq_detector #(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 8'b0011_0101,
  parameter int               LEN_DEFAULT = 6,
  localparam int              LEN_W       = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             data_out,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] fill
);

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] act_pat;
  logic [LEN_W-1:0] act_len;

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   fill_p1;
  logic             fill_full;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] len_clamped;
  logic             match;
  logic             unused_hist_msb;

  // The oldest history bit only ever shifts out; matching uses the updated history.
  assign unused_hist_msb = history[PAT_W-1];

  assign hist_nxt    = {history[PAT_W-2:0], data_in};
  assign fill_p1     = {1'b0, fill} + (LEN_W+1)'(1);
  assign fill_full   = fill_p1 >= {1'b0, act_len};
  assign fill_inc    = fill_full ? act_len : fill_p1[LEN_W-1:0];
  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(act_len));
    end
  end

  // A length of zero never matches, even though the empty mask would compare equal.
  assign match = data_valid && !cfg_load && (act_len != '0) && fill_full &&
                 (((hist_nxt ^ act_pat) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      history     <= '0;
      fill        <= '0;
      data_out    <= 1'b0;
      match_count <= '0;
      act_pat     <= PAT_DEFAULT;
      act_len     <= LEN_W'(LEN_DEFAULT);
    end else begin
      data_out <= match;

      if (cfg_load) begin
        act_pat <= cfg_pattern;
        act_len <= len_clamped;
        fill    <= '0;
      end else if (data_valid) begin
        history <= hist_nxt;
        if (match && !overlap_en) fill <= '0;
        else                      fill <= fill_inc;
      end

      if (cnt_clr)                            match_count <= '0;
      else if (match && (match_count != '1)) match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/param_seq_detector.md
PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (legal 2..32).
REQ-002 Parameter CNT_W, default 16, match counter width.
REQ-003 Parameter PAT_DEFAULT, default 8'b0011_0101, pattern loaded at reset (low 6 bits = 110101).
REQ-004 Parameter LEN_DEFAULT, default 6, pattern length loaded at reset.
REQ-005 Derived LEN_W = clog2(PAT_W)+1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 data_in  input  1  serial data bit.
REQ-009 data_valid  input  1  data_in is sampled only when high.
REQ-010 cfg_load  input  1  one-cycle strobe that latches cfg_pattern/cfg_len.
REQ-011 cfg_pattern  input  PAT_W  new pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-012 cfg_len  input  LEN_W  new pattern length.
REQ-013 overlap_en  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-014 cnt_clr  input  1  synchronous clear of match_count.
REQ-015 data_out  output  1  registered one-cycle match pulse.
REQ-016 match_count  output  CNT_W  saturating count of matches.
REQ-017 fill  output  LEN_W  number of valid history bits, saturating at the active length.

Function
REQ-018 The block SHALL hold a PAT_W-bit history shift register; on each data_valid cycle, history <= {history[PAT_W-2:0], data_in}.
REQ-019 fill SHALL increment on each data_valid cycle and saturate at the active length.
REQ-020 A match SHALL occur on a data_valid cycle when fill (including the current bit) >= active length and the low active-length bits of the updated history equal the low active-length bits of the active pattern.
REQ-021 data_out SHALL assert in the cycle immediately after the clock edge that samples the completing bit, for exactly one cycle per match.
REQ-022 data_out SHALL be low in every cycle that does not follow a match, including cycles after data_valid=0.
REQ-023 When overlap_en=1, history and fill SHALL be kept after a match, so a pattern 101 on stream 10101 gives two matches.
REQ-024 When overlap_en=0, fill SHALL be cleared to 0 on the match edge, so the next match needs a full new pattern.
REQ-025 cfg_load SHALL latch the pattern and length, clear fill to 0, and discard any data_in sampled in the same cycle; match_count SHALL be unchanged.
REQ-026 A cfg_len of 0 SHALL disable detection: there are no matches and fill stays 0.
REQ-027 A cfg_len greater than PAT_W SHALL be clamped to PAT_W.
REQ-028 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-029 If cnt_clr and a match occur in the same cycle, cnt_clr SHALL win and match_count SHALL become 0; data_out SHALL still pulse.
REQ-030 An overlap_en change SHALL take effect on the next data_valid cycle and SHALL NOT alter fill by itself.

Reset
REQ-031 When rst=1 on a rising edge, the block SHALL set history=0, fill=0, data_out=0, match_count=0, active pattern=PAT_DEFAULT and active length=LEN_DEFAULT.
REQ-032 rst SHALL override cfg_load, cnt_clr and data_valid in the same cycle.
REQ-033 A reset asserted mid-pattern SHALL discard partial progress, so the full pattern is needed again after release.

Verification
REQ-034 Reset defaults, overlap_en=1, stream 1,1,0,1,0,1 on consecutive valid cycles -> data_out=1 for exactly one cycle after the 6th bit; match_count=1.
REQ-035 cfg_load with pattern 101 and len 3, then stream 1,0,1,0,1 -> two pulses with overlap_en=1 (count 2); repeated after reset with overlap_en=0 -> one pulse (count 1).
REQ-036 Reset defaults, stream 1,1,0 then data_valid=0 for 5 cycles, then 1,0,1 -> one match; data_out stays low during the gap.
REQ-037 CNT_W=2, 5 back-to-back matches -> match_count reads 1,2,3,3,3; cnt_clr asserted with a 6th match -> count 0 and data_out pulses.
REQ-038 rst after bits 1,1,0,1,0, then bit 1 -> no pulse; a full 110101 afterwards -> one pulse.
REQ-039 cfg_len=0 with random 200-bit stream -> data_out never asserts; cfg_len=15 with PAT_W=8 -> behaves as len 8.
